// File: rtl/fibo_pkg.sv
// Shared encodings for the Fibonacci stream generator.
package fibo_pkg;

    // Overflow policy encodings; the fourth code is reserved and behaves as wrap.
    localparam logic [1:0] FIBO_WRAP    = 2'd0;
    localparam logic [1:0] FIBO_RESTART = 2'd1;
    localparam logic [1:0] FIBO_HALT    = 2'd2;

    // Generator FSM states.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

endpackage

// File: rtl/fibo_gen_param_step_add.sv
// Width-generic adder returning the truncated sum and the carry out.
module fibo_step_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_c,
    output logic             carry_c
);

    // Extend both operands by one bit so the carry lands in the top bit.
    assign {carry_c, sum_c} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/fibo_gen_param.sv
// Parametrised Fibonacci stream source with loadable seeds, valid/ready output
// and selectable overflow policy (wrap, restart, halt).
module fibo_gen_param
    import fibo_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter int unsigned     IDX_W = 8,
    parameter logic [WIDTH-1:0] SEED0 = WIDTH'(0),
    parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [1:0]       mode,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fibo_series,
    output logic             out_valid,
    output logic [IDX_W-1:0] term_idx,
    output logic             overflow,
    output logic             done
);

    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] nxt_q, nxt_d;
    logic             nxt_ovf_q, nxt_ovf_d;
    logic [WIDTH-1:0] s0_q, s0_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic [0:0]       state_q, state_d;

    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             xfer_c;

    // Next-term adder: cur + nxt with carry.
    fibo_step_add #(
        .WIDTH (WIDTH)
    ) u_step_add (
        .a_i     (cur_q),
        .b_i     (nxt_q),
        .sum_c   (sum_c),
        .carry_c (carry_c)
    );

    // Valid is gated by reset so nothing is offered while reset is held low.
    assign out_valid = en && reset && (state_q == ST_RUN);
    assign xfer_c    = out_valid && out_ready;

    // Next-state logic: load has priority over a transfer in the same cycle.
    always_comb begin
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        nxt_ovf_d  = nxt_ovf_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        done_d     = done_q;
        state_d    = state_q;

        if (load) begin
            s0_d       = seed_a;
            s1_d       = seed_b;
            cur_d      = seed_a;
            nxt_d      = seed_b;
            nxt_ovf_d  = 1'b0;
            idx_d      = '0;
            overflow_d = 1'b0;
            done_d     = 1'b0;
            state_d    = ST_RUN;
        end else if (xfer_c) begin
            if (!nxt_ovf_q) begin
                cur_d     = nxt_q;
                nxt_d     = sum_c;
                nxt_ovf_d = carry_c;
                idx_d     = idx_q + IDX_W'(1);
            end else begin
                case (mode)
                    FIBO_RESTART: begin
                        cur_d     = s0_q;
                        nxt_d     = s1_q;
                        nxt_ovf_d = 1'b0;
                        idx_d     = '0;
                    end
                    FIBO_HALT: begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                    default: begin
                        // Wrap (and the reserved code): keep going, flag the truncation.
                        cur_d      = nxt_q;
                        nxt_d      = sum_c;
                        nxt_ovf_d  = carry_c;
                        idx_d      = idx_q + IDX_W'(1);
                        overflow_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_q      <= SEED0;
            nxt_q      <= SEED1;
            nxt_ovf_q  <= 1'b0;
            s0_q       <= SEED0;
            s1_q       <= SEED1;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            state_q    <= ST_RUN;
        end else begin
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            nxt_ovf_q  <= nxt_ovf_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            state_q    <= state_d;
        end
    end

    assign fibo_series = cur_q;
    assign term_idx    = idx_q;
    assign overflow    = overflow_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fibo_gen_param.sv
// Directed table-driven bench for fibo_gen_param (WIDTH=8, IDX_W=8).
module tb_fibo_gen_param;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       rdy;
        logic       load;
        logic [1:0] mode;
        logic [7:0] sa;
        logic [7:0] sb;
        logic       ev;
        logic [7:0] es;
        logic [7:0] ei;
        logic       eo;
        logic       ed;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] seed_a;
    logic [7:0] seed_b;
    logic [1:0] mode;
    logic       out_ready;
    logic [7:0] fibo_series;
    logic       out_valid;
    logic [7:0] term_idx;
    logic       overflow;
    logic       done;

    int total = 0;
    int bad   = 0;

    vec_t vq[$];
    logic [7:0] fib [0:13];

    fibo_gen_param #(
        .WIDTH (8),
        .IDX_W (8),
        .SEED0 (8'd0),
        .SEED1 (8'd1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .seed_a      (seed_a),
        .seed_b      (seed_b),
        .mode        (mode),
        .out_ready   (out_ready),
        .fibo_series (fibo_series),
        .out_valid   (out_valid),
        .term_idx    (term_idx),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic r, input logic e, input logic rd, input logic ld,
                                 input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                                 input logic ev, input logic [7:0] es, input logic [7:0] ei,
                                 input logic eo, input logic ed);
        vec_t v;
        v.rst_n = r; v.en = e; v.rdy = rd; v.load = ld; v.mode = m; v.sa = a; v.sb = b;
        v.ev = ev; v.es = es; v.ei = ei; v.eo = eo; v.ed = ed;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int n, input logic [7:0] act, input logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, n, act, exp_v);
        end
    endtask

    initial begin
        fib = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                8'd55, 8'd89, 8'd144, 8'd233};

        // Reset state: held low with en=1, nothing offered.
        reset = 1'b0; en = 1'b1; load = 1'b0; seed_a = '0; seed_b = '0;
        mode = 2'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", -1, 8'(out_valid), 8'd0);
        chk("rst_series", -1, fibo_series, 8'd0);
        chk("rst_idx", -1, term_idx, 8'd0);
        chk("rst_ovf", -1, 8'(overflow), 8'd0);
        chk("rst_done", -1, 8'(done), 8'd0);
        @(posedge clk); #1;

        // WRAP run from reset seeds, continuing past 233.
        for (int i = 0; i < 14; i++) push(1, 1, 1, 0, 2'd0, 0, 0, 1, fib[i], 8'(i), 0, 0);
        push(1, 1, 1, 0, 2'd0, 0, 0, 1, 8'd121, 8'd14, 1, 0);
        push(1, 1, 1, 0, 2'd0, 0, 0, 1, 8'd98,  8'd15, 1, 0);
        // Load coincident with a transfer: state shows 219 this cycle, load wins.
        push(1, 1, 1, 1, 2'd1, 0, 1, 1, 8'd219, 8'd16, 1, 0);

        // RESTART run.
        for (int i = 0; i < 14; i++) push(1, 1, 1, 0, 2'd1, 0, 0, 1, fib[i], 8'(i), 0, 0);
        push(1, 1, 1, 0, 2'd1, 0, 0, 1, 8'd0, 8'd0, 0, 0);
        push(1, 1, 1, 0, 2'd1, 0, 0, 1, 8'd1, 8'd1, 0, 0);
        push(1, 1, 1, 0, 2'd1, 0, 0, 1, 8'd1, 8'd2, 0, 0);
        push(1, 1, 1, 1, 2'd2, 0, 1, 1, 8'd2, 8'd3, 0, 0);

        // HALT run: 233 accepted, then stuck until a load.
        for (int i = 0; i < 14; i++) push(1, 1, 1, 0, 2'd2, 0, 0, 1, fib[i], 8'(i), 0, 0);
        push(1, 1, 1, 0, 2'd2, 0, 0, 0, 8'd233, 8'd13, 0, 1);
        push(1, 1, 1, 0, 2'd2, 0, 0, 0, 8'd233, 8'd13, 0, 1);
        push(1, 1, 1, 1, 2'd2, 2, 3, 0, 8'd233, 8'd13, 0, 1);
        push(1, 1, 1, 0, 2'd2, 0, 0, 1, 8'd2, 8'd0, 0, 0);
        push(1, 1, 1, 0, 2'd2, 0, 0, 1, 8'd3, 8'd1, 0, 0);
        push(1, 1, 1, 0, 2'd2, 0, 0, 1, 8'd5, 8'd2, 0, 0);
        push(1, 1, 1, 1, 2'd0, 0, 1, 1, 8'd8, 8'd3, 0, 0);

        // Backpressure: ready toggles, each term held for two cycles.
        for (int k = 0; k < 6; k++) begin
            push(1, 1, 0, 0, 2'd0, 0, 0, 1, fib[k], 8'(k), 0, 0);
            push(1, 1, 1, 0, 2'd0, 0, 0, 1, fib[k], 8'(k), 0, 0);
        end
        // Load coincident with transfer of 8: idx restarts at 0 with new seeds.
        push(1, 1, 1, 1, 2'd0, 5, 7, 1, 8'd8, 8'd6, 0, 0);
        push(1, 1, 1, 0, 2'd0, 0, 0, 1, 8'd5, 8'd0, 0, 0);
        push(1, 1, 1, 0, 2'd0, 0, 0, 1, 8'd7, 8'd1, 0, 0);
        // en=0 drops valid and holds state.
        push(1, 0, 1, 0, 2'd0, 0, 0, 0, 8'd12, 8'd2, 0, 0);
        push(1, 1, 1, 1, 2'd0, 0, 1, 1, 8'd12, 8'd2, 0, 0);

        // Mid-series reset at term 34.
        for (int i = 0; i < 9; i++) push(1, 1, 1, 0, 2'd0, 0, 0, 1, fib[i], 8'(i), 0, 0);
        push(1, 1, 0, 0, 2'd0, 0, 0, 1, 8'd34, 8'd9, 0, 0);
        push(0, 1, 1, 0, 2'd0, 0, 0, 0, 8'd34, 8'd9, 0, 0);
        push(1, 1, 1, 0, 2'd0, 0, 0, 1, 8'd0, 8'd0, 0, 0);
        push(1, 1, 1, 0, 2'd0, 0, 0, 1, 8'd1, 8'd1, 0, 0);

        foreach (vq[n]) begin
            reset     = vq[n].rst_n;
            en        = vq[n].en;
            out_ready = vq[n].rdy;
            load      = vq[n].load;
            mode      = vq[n].mode;
            seed_a    = vq[n].sa;
            seed_b    = vq[n].sb;
            @(negedge clk);
            chk("valid", n, 8'(out_valid), 8'(vq[n].ev));
            chk("series", n, fibo_series, vq[n].es);
            chk("idx", n, term_idx, vq[n].ei);
            chk("overflow", n, 8'(overflow), 8'(vq[n].eo));
            chk("done", n, 8'(done), 8'(vq[n].ed));
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
